// File: rtl/img_ram_rsize_axis.sv
// Per-axis resize table generator: computes the output ROI from a scale factor and pan, then fills
// a double-buffered table of {valid, source index, fraction} that swaps only on a frame boundary.
module img_ram_rsize_axis #(
    parameter int unsigned SRC_LEN = 640,
    parameter int unsigned DST_LEN = 1080,
    parameter int unsigned FRAC_W  = 5,
    parameter int unsigned RATE_W  = 11,
    parameter int unsigned POS_W   = 16,
    parameter int unsigned IDX_W   = 10,
    parameter int unsigned ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RATE_W-1:0] i_fix_rate,
    input  logic [RATE_W-1:0] i_rate_coe,
    input  logic [POS_W-1:0]  i_offset,
    input  logic              i_mode,
    input  logic              i_rate_coe_vld,
    input  logic              i_frame_start,
    output logic [RATE_W-1:0] o_rate_coe,
    output logic [POS_W-1:0]  o_roi_b,
    output logic [POS_W-1:0]  o_roi_e,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_tbl_valid,
    input  logic [ADDR_W-1:0] i_ram_raddr,
    input  logic              i_ram_re,
    output logic              o_ram_vld,
    output logic              o_src_vld,
    output logic [IDX_W-1:0]  o_src_idx,
    output logic [IDX_W-1:0]  o_src_idx1,
    output logic [FRAC_W-1:0] o_frac
);
    localparam int unsigned PW = POS_W + RATE_W;
    localparam int unsigned IW = PW - FRAC_W;
    localparam int unsigned WW = 1 + IDX_W + FRAC_W;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SRC_LEN - 1);

    typedef enum logic [2:0] {StIdle, StCalc, StRoi, StFill, StDrain} state_e;

    state_e                    state;
    logic [ADDR_W-1:0]         cnt;
    logic [1:0]                dcnt;
    logic                      ready, pend;
    logic [RATE_W-1:0]         sh_rate, sh_coe, pd_rate, pd_coe;
    logic signed [POS_W-1:0]   sh_off, pd_off, sh_roi_b, sh_roi_e;
    logic                      sh_mode, pd_mode, act, act_mode;
    logic [POS_W-1:0]          len_q;

    logic [31:0]               len_full;
    logic [POS_W-1:0]          len_calc;
    logic signed [POS_W-1:0]   roi_b_c, roi_e_c, n_s;
    logic                      last_drain;

    always_comb begin
        len_full   = SRC_LEN * 32'(sh_rate);
        len_calc   = POS_W'(len_full >> FRAC_W);
        roi_b_c    = POS_W'(DST_LEN / 2) - (len_q >> 1) + sh_off;
        roi_e_c    = POS_W'(DST_LEN / 2) + (len_q >> 1) - POS_W'(1) + sh_off;
        n_s        = $signed(POS_W'(cnt));
        last_drain = (state == StDrain) && (dcnt == 2'd2);
    end

    assign o_busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;  cnt <= '0;  dcnt <= '0;  ready <= 1'b0;  pend <= 1'b0;
            sh_rate <= '0;  sh_coe <= '0;  sh_off <= '0;  sh_mode <= 1'b0;
            pd_rate <= '0;  pd_coe <= '0;  pd_off <= '0;  pd_mode <= 1'b0;
            len_q <= '0;  sh_roi_b <= '0;  sh_roi_e <= '0;  act <= 1'b0;  act_mode <= 1'b0;
            o_rate_coe <= '0;  o_roi_b <= '0;  o_roi_e <= '0;  o_tbl_valid <= 1'b0;  o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_frame_start && ready && state == StIdle) begin
                act         <= ~act;
                act_mode    <= sh_mode;
                o_rate_coe  <= sh_coe;
                o_roi_b     <= sh_roi_b;
                o_roi_e     <= sh_roi_e;
                o_tbl_valid <= 1'b1;
                ready       <= 1'b0;
            end
            if (state != StIdle && i_rate_coe_vld) begin
                pend    <= 1'b1;
                pd_rate <= i_fix_rate;
                pd_coe  <= i_rate_coe;
                pd_off  <= i_offset;
                pd_mode <= i_mode;
            end
            case (state)
                StIdle: if (i_rate_coe_vld) begin
                    sh_rate <= i_fix_rate;
                    sh_coe  <= i_rate_coe;
                    sh_off  <= i_offset;
                    sh_mode <= i_mode;
                    ready   <= 1'b0;
                    state   <= StCalc;
                end
                StCalc: begin
                    len_q <= len_calc;
                    state <= StRoi;
                end
                StRoi: begin
                    sh_roi_b <= roi_b_c;
                    sh_roi_e <= roi_e_c;
                    cnt      <= '0;
                    state    <= StFill;
                end
                StFill: begin
                    if (cnt == ADDR_W'(DST_LEN - 1)) begin
                        dcnt  <= '0;
                        state <= StDrain;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (last_drain) begin
                        // A strobe on this very edge is the latest one and overrides pending.
                        if (pend || i_rate_coe_vld) begin
                            sh_rate <= i_rate_coe_vld ? i_fix_rate : pd_rate;
                            sh_coe  <= i_rate_coe_vld ? i_rate_coe : pd_coe;
                            sh_off  <= i_rate_coe_vld ? i_offset   : pd_off;
                            sh_mode <= i_rate_coe_vld ? i_mode     : pd_mode;
                            pend    <= 1'b0;
                            state   <= StCalc;
                        end else begin
                            ready  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= StIdle;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Fill pipeline: index/compare, multiply, clamp; the table write follows stage 3.
    logic              p1_v, p1_vld, p2_v, p2_vld, p3_v;
    logic [POS_W-1:0]  p1_d;
    logic [PW-1:0]     p2_pos;
    logic [ADDR_W-1:0] p1_addr, p2_addr, p3_addr;
    logic [WW-1:0]     p3_word;
    logic [IW-1:0]     s3_int;
    logic              s3_clamp;
    logic [IDX_W-1:0]  s3_idx;
    logic [FRAC_W-1:0] s3_f;

    always_comb begin
        s3_int   = p2_pos[PW-1:FRAC_W];
        s3_clamp = s3_int > IW'(SRC_LEN - 1);
        s3_idx   = s3_clamp ? IDX_MAX : s3_int[IDX_W-1:0];
        s3_f     = s3_clamp ? '0 : p2_pos[FRAC_W-1:0];
        if (!p2_vld) begin
            s3_idx = '0;
            s3_f   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0;  p1_vld <= 1'b0;  p1_d <= '0;  p1_addr <= '0;
            p2_v <= 1'b0;  p2_vld <= 1'b0;  p2_pos <= '0;  p2_addr <= '0;
            p3_v <= 1'b0;  p3_word <= '0;  p3_addr <= '0;
        end else begin
            p1_v    <= (state == StFill);
            p1_vld  <= (n_s >= sh_roi_b) && (n_s <= sh_roi_e);
            p1_d    <= n_s - sh_roi_b;
            p1_addr <= cnt;
            p2_v    <= p1_v;
            p2_vld  <= p1_vld;
            p2_pos  <= PW'(p1_d) * PW'(sh_coe);
            p2_addr <= p1_addr;
            p3_v    <= p2_v;
            p3_word <= {p2_vld, s3_idx, s3_f};
            p3_addr <= p2_addr;
        end
    end

    logic [WW-1:0] mem0 [DST_LEN];
    logic [WW-1:0] mem1 [DST_LEN];
    logic [WW-1:0] ra_word;
    logic          ra_vld, ra_oob, ra_mode;

    // Writes always target the shadow bank; reads always the active one.
    always_ff @(posedge clk) begin
        if (p3_v) begin
            if (act) mem0[p3_addr] <= p3_word;
            else     mem1[p3_addr] <= p3_word;
        end
        if (i_ram_re) ra_word <= act ? mem1[i_ram_raddr] : mem0[i_ram_raddr];
    end

    logic [IDX_W-1:0]  r_int, near_idx, nb_idx;
    logic [FRAC_W-1:0] r_f;
    logic [IDX_W:0]    near_sum, nb_sum;

    always_comb begin
        r_int    = ra_word[FRAC_W +: IDX_W];
        r_f      = ra_word[FRAC_W-1:0];
        near_sum = {1'b0, r_int} + {{IDX_W{1'b0}}, r_f[FRAC_W-1]};
        nb_sum   = {1'b0, r_int} + (IDX_W + 1)'(1);
        near_idx = (near_sum > {1'b0, IDX_MAX}) ? IDX_MAX : near_sum[IDX_W-1:0];
        nb_idx   = (nb_sum > {1'b0, IDX_MAX}) ? IDX_MAX : nb_sum[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_vld <= 1'b0;  ra_oob <= 1'b0;  ra_mode <= 1'b0;
            o_ram_vld <= 1'b0;  o_src_vld <= 1'b0;
            o_src_idx <= '0;  o_src_idx1 <= '0;  o_frac <= '0;
        end else begin
            ra_vld    <= i_ram_re;
            o_ram_vld <= ra_vld;
            if (i_ram_re) begin
                ra_oob  <= (i_ram_raddr >= ADDR_W'(DST_LEN));
                ra_mode <= act_mode;
            end
            if (ra_vld) begin
                if (ra_oob) begin
                    o_src_vld  <= 1'b0;
                    o_src_idx  <= '0;
                    o_src_idx1 <= '0;
                    o_frac     <= '0;
                end else if (ra_mode) begin
                    o_src_vld  <= ra_word[WW-1];
                    o_src_idx  <= r_int;
                    o_src_idx1 <= nb_idx;
                    o_frac     <= r_f;
                end else begin
                    o_src_vld  <= ra_word[WW-1];
                    o_src_idx  <= near_idx;
                    o_src_idx1 <= near_idx;
                    o_frac     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_img_ram_rsize_axis.sv
// Directed bench for img_ram_rsize_axis: ROI/table contents, fill latency, frame-boundary swap,
// reload during fill and asynchronous reset mid-fill.
module tb_img_ram_rsize_axis;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] i_fix_rate, i_rate_coe;
    logic [15:0] i_offset;
    logic        i_mode, i_rate_coe_vld, i_frame_start;
    logic [10:0] o_rate_coe;
    logic [15:0] o_roi_b, o_roi_e;
    logic        o_busy, o_done, o_tbl_valid;
    logic [10:0] i_ram_raddr;
    logic        i_ram_re;
    logic        o_ram_vld, o_src_vld;
    logic [9:0]  o_src_idx, o_src_idx1;
    logic [4:0]  o_frac;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    img_ram_rsize_axis dut (
        .clk(clk), .rst_n(rst_n),
        .i_fix_rate(i_fix_rate), .i_rate_coe(i_rate_coe), .i_offset(i_offset), .i_mode(i_mode),
        .i_rate_coe_vld(i_rate_coe_vld), .i_frame_start(i_frame_start),
        .o_rate_coe(o_rate_coe), .o_roi_b(o_roi_b), .o_roi_e(o_roi_e),
        .o_busy(o_busy), .o_done(o_done), .o_tbl_valid(o_tbl_valid),
        .i_ram_raddr(i_ram_raddr), .i_ram_re(i_ram_re),
        .o_ram_vld(o_ram_vld), .o_src_vld(o_src_vld),
        .o_src_idx(o_src_idx), .o_src_idx1(o_src_idx1), .o_frac(o_frac)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int rate, input int coe, input int off, input bit mode);
        i_fix_rate     = 11'(rate);
        i_rate_coe     = 11'(coe);
        i_offset       = 16'(off);
        i_mode         = mode;
        i_rate_coe_vld = 1'b1;
        @(negedge clk);
        i_rate_coe_vld = 1'b0;
    endtask

    // Counts cycles after the strobe edge until o_done is seen; optionally raises
    // i_frame_start so it is sampled on the same edge that sets ready.
    task automatic wait_done(input bit fs_pre, output int lat);
        lat = 0;
        while (!o_done && lat < 1200) begin
            if (fs_pre && lat == 1084) i_frame_start = 1'b1;
            @(negedge clk);
            i_frame_start = 1'b0;
            lat++;
        end
    endtask

    task automatic swap();
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input int a, input int ev, input int ei,
                          input int ei1, input int ef);
        i_ram_raddr = 11'(a);
        i_ram_re    = 1'b1;
        @(negedge clk);
        i_ram_re = 1'b0;
        @(negedge clk);
        chk({tag, ".rvld"}, 32'(o_ram_vld), 32'd1);
        chk({tag, ".vld"}, 32'(o_src_vld), 32'(ev));
        chk({tag, ".idx"}, 32'(o_src_idx), 32'(ei));
        chk({tag, ".idx1"}, 32'(o_src_idx1), 32'(ei1));
        chk({tag, ".frac"}, 32'(o_frac), 32'(ef));
    endtask

    int lat;
    int done_cnt;
    bit early_swap;

    initial begin
        rst_n = 1'b0;  i_fix_rate = '0;  i_rate_coe = '0;  i_offset = '0;  i_mode = 1'b0;
        i_rate_coe_vld = 1'b0;  i_frame_start = 1'b0;  i_ram_raddr = '0;  i_ram_re = 1'b0;
        cyc(3);
        chk("rst.tbl_valid", 32'(o_tbl_valid), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        chk("rst.roi_b", 32'(o_roi_b), 32'd0);
        chk("rst.ram_vld", 32'(o_ram_vld), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 1:1 nearest, centred
        strobe(32, 32, 0, 1'b0);
        chk("t1.busy", 32'(o_busy), 32'd1);
        wait_done(1'b1, lat);
        chk("t1.done_lat", 32'(lat), 32'd1085);
        chk("t1.no_swap_at_done", 32'(o_tbl_valid), 32'd0);
        @(negedge clk);
        chk("t1.done_pulse", 32'(o_done), 32'd0);
        chk("t1.idle", 32'(o_busy), 32'd0);
        swap();
        chk("t1.tbl_valid", 32'(o_tbl_valid), 32'd1);
        chk("t1.roi_b", 32'(o_roi_b), 32'd220);
        chk("t1.roi_e", 32'(o_roi_e), 32'd859);
        chk("t1.rate_coe", 32'(o_rate_coe), 32'd32);
        chk_rd("t1.l219", 219, 0, 0, 0, 0);
        chk_rd("t1.l220", 220, 1, 0, 0, 0);
        chk_rd("t1.l859", 859, 1, 639, 639, 0);
        chk_rd("t1.l860", 860, 0, 0, 0, 0);
        chk_rd("t1.oob", 2000, 0, 0, 0, 0);

        // 1.5x bilinear
        strobe(48, 21, 0, 1'b1);
        wait_done(1'b0, lat);
        chk("t2.done_lat", 32'(lat), 32'd1085);
        swap();
        chk("t2.roi_b", 32'(o_roi_b), 32'd60);
        chk("t2.roi_e", 32'(o_roi_e), 32'd1019);
        chk_rd("t2.l61", 61, 1, 0, 1, 21);
        chk_rd("t2.l1019", 1019, 1, 629, 630, 11);

        // same table, nearest
        strobe(48, 21, 0, 1'b0);
        wait_done(1'b0, lat);
        swap();
        chk_rd("t3.l61", 61, 1, 1, 1, 0);

        // 2x, ROI starts off-screen
        strobe(64, 16, 0, 1'b1);
        wait_done(1'b0, lat);
        swap();
        chk("t4.roi_b", 32'(o_roi_b), 32'(16'hff9c));
        chk("t4.roi_e", 32'(o_roi_e), 32'd1179);
        chk_rd("t4.l0", 0, 1, 50, 51, 0);
        chk_rd("t4.l1079", 1079, 1, 589, 590, 16);

        // clamp at the far edge, panned by +10
        strobe(32, 33, 10, 1'b1);
        wait_done(1'b0, lat);
        swap();
        chk("t5.roi_b", 32'(o_roi_b), 32'd230);
        chk("t5.roi_e", 32'(o_roi_e), 32'd869);
        chk_rd("t5.l869", 869, 1, 639, 639, 0);

        // reload at n = 500, frame start during the refill
        strobe(32, 32, 0, 1'b0);
        cyc(502);
        strobe(48, 21, 0, 1'b1);
        done_cnt   = 0;
        early_swap = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) i_frame_start = 1'b1;
            @(negedge clk);
            i_frame_start = 1'b0;
            if (o_done) done_cnt++;
            if (o_roi_b !== 16'd230) early_swap = 1'b1;
        end
        chk("t6.done_cnt", 32'(done_cnt), 32'd1);
        chk("t6.early_swap", 32'(early_swap), 32'd0);
        chk_rd("t6.old_l869", 869, 1, 639, 639, 0);
        swap();
        chk("t6.roi_b", 32'(o_roi_b), 32'd60);
        chk("t6.rate_coe", 32'(o_rate_coe), 32'd21);
        chk_rd("t6.l61", 61, 1, 0, 1, 21);

        // asynchronous reset mid-fill
        strobe(64, 16, 0, 1'b1);
        cyc(300);
        chk("t7.busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7.tbl_valid", 32'(o_tbl_valid), 32'd0);
        chk("t7.busy_rst", 32'(o_busy), 32'd0);
        chk("t7.roi_b", 32'(o_roi_b), 32'd0);
        chk("t7.roi_e", 32'(o_roi_e), 32'd0);
        chk("t7.rate_coe", 32'(o_rate_coe), 32'd0);
        chk("t7.idx", 32'(o_src_idx), 32'd0);
        chk("t7.frac", 32'(o_frac), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        swap();
        chk("t7.no_swap", 32'(o_tbl_valid), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
        chk("t7.no_done", 32'(done_cnt), 32'd0);
        chk("t7.idle", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
